// File: rtl/parallel_bus_slave_autoincrement_pkg.sv
// Shared encodings for the parallel bus slave: bus-role values and prefetch states.
package parallel_bus_slave_autoincrement_pkg;

  localparam logic REGISTER_SELECT_ADDRESS = 1'b0;
  localparam logic REGISTER_SELECT_DATA    = 1'b1;
  localparam logic BUS_WRITE               = 1'b0;
  localparam logic BUS_READ                = 1'b1;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_REQ     = 2'd1,
    PF_CAPTURE = 2'd2
  } prefetch_state_e;

endpackage

// File: rtl/parallel_bus_slave_autoincrement_bus_input_synchronizer.sv
// Two-flop synchroniser for an N-bit bus plus its strobe, with a rising-edge
// detector on the synchronised strobe. Reusable by any asynchronous bus slave.
module bus_input_synchronizer #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic         enable_in,
  output logic [N-1:0] data_out,
  output logic         enable_out,
  output logic         enable_rise
);

  logic [N:0] meta_q, meta_d;
  logic [N:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    meta_d = {enable_in, data_in};
    sync_d = meta_q;
    prev_d = sync_q[N];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign data_out    = sync_q[N-1:0];
  assign enable_out  = sync_q[N];
  assign enable_rise = sync_q[N] & ~prev_q;

endmodule

// File: rtl/parallel_bus_slave_autoincrement.sv
// Parallel bus slave bridging multi-transfer address/data phases to a synchronous
// memory port. Define PARALLEL_BUS_ADDRESS_AUTOINCREMENT_EN for burst address stepping.
module parallel_bus_slave_autoincrement
  import parallel_bus_slave_autoincrement_pkg::*;
#(
  parameter int WIDTH                 = 8,
  parameter int ADDRESS_TRANSACTIONS  = 2,
  parameter int TRANSACTIONS_PER_WORD = 4,
  parameter int ERROR_COUNTER_WIDTH   = 16
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [WIDTH-1:0]                        bus_in,
  output logic [WIDTH-1:0]                        bus_out,
  output logic                                    bus_output_enable,
  input  logic                                    read,
  input  logic                                    register_select,
  input  logic                                    enable,
  output logic                                    ack_valid,
  output logic [ADDRESS_TRANSACTIONS*WIDTH-1:0]   mem_address,
  output logic [TRANSACTIONS_PER_WORD*WIDTH-1:0]  mem_write_data,
  output logic                                    mem_write_strobe,
  output logic                                    mem_read_strobe,
  input  logic [TRANSACTIONS_PER_WORD*WIDTH-1:0]  mem_read_data,
  output logic [ERROR_COUNTER_WIDTH-1:0]          errors
);

  localparam int ADDRESS_WIDTH = ADDRESS_TRANSACTIONS * WIDTH;
  localparam int DATA_WIDTH    = TRANSACTIONS_PER_WORD * WIDTH;
  localparam int WCW = (TRANSACTIONS_PER_WORD > 1) ? $clog2(TRANSACTIONS_PER_WORD) : 1;
  localparam int ACW = (ADDRESS_TRANSACTIONS > 1) ? $clog2(ADDRESS_TRANSACTIONS) : 1;
  localparam logic [WCW-1:0] WORD_LAST = WCW'(TRANSACTIONS_PER_WORD - 1);
  localparam logic [ACW-1:0] ADDR_LAST = ACW'(ADDRESS_TRANSACTIONS - 1);

  function automatic logic [ERROR_COUNTER_WIDTH-1:0] sat_inc(
    input logic [ERROR_COUNTER_WIDTH-1:0] v
  );
    return (&v) ? v : ERROR_COUNTER_WIDTH'(v + 1'b1);
  endfunction

  logic [WIDTH-1:0] s_bus;
  logic             s_read, s_rs, s_en, ev;

  bus_input_synchronizer #(.N(WIDTH + 2)) u_sync (
    .clock       (clock),
    .reset       (reset),
    .data_in     ({read, register_select, bus_in}),
    .enable_in   (enable),
    .data_out    ({s_read, s_rs, s_bus}),
    .enable_out  (s_en),
    .enable_rise (ev)
  );

  logic [ADDRESS_WIDTH-1:0]       addr_asm_q, addr_asm_d;
  logic [ADDRESS_WIDTH-1:0]       mem_address_q, mem_address_d;
  logic [ACW-1:0]                 addr_cnt_q, addr_cnt_d;
  logic [WCW-1:0]                 wword_q, wword_d;
  logic [WCW-1:0]                 rword_q, rword_d;
  logic [DATA_WIDTH-1:0]          mem_write_data_q, mem_write_data_d;
  logic [DATA_WIDTH-1:0]          pf_buf_q, pf_buf_d;
  logic [WIDTH-1:0]               bus_out_q, bus_out_d;
  logic [ERROR_COUNTER_WIDTH-1:0] errors_q, errors_d;
  logic                           wr_strobe_q, wr_strobe_d;
  logic                           step_q, step_d;
  logic                           ack_q, ack_d;
  prefetch_state_e                pf_state_q, pf_state_d;
  logic                           pf_req, err_ev, pending;
  logic [ADDRESS_WIDTH-1:0]       addr_shifted;

  always_comb begin
    addr_asm_d       = addr_asm_q;
    mem_address_d    = mem_address_q;
    addr_cnt_d       = addr_cnt_q;
    wword_d          = wword_q;
    rword_d          = rword_q;
    mem_write_data_d = mem_write_data_q;
    pf_buf_d         = pf_buf_q;
    bus_out_d        = bus_out_q;
    errors_d         = errors_q;
    wr_strobe_d      = 1'b0;
    step_d           = 1'b0;
    ack_d            = s_en;
    pf_state_d       = pf_state_q;
    pf_req           = 1'b0;
    err_ev           = 1'b0;
    pending          = (pf_state_q != PF_IDLE) || step_q;
    addr_shifted     = ADDRESS_WIDTH'({addr_asm_q, s_bus});

    // Address step lands one clock after the word completes; the prefetch then
    // sees the stepped address. A same-cycle address event below overrides it.
    if (step_q) begin
`ifdef PARALLEL_BUS_ADDRESS_AUTOINCREMENT_EN
      mem_address_d = mem_address_q + 1'b1;
`endif
      pf_req = 1'b1;
    end

    if (ev) begin
      err_ev = pending;
      case ({s_rs, s_read})
        {REGISTER_SELECT_ADDRESS, BUS_WRITE}: begin
          if (wword_q != WORD_LAST || rword_q != WORD_LAST) err_ev = 1'b1;
          wword_d    = WORD_LAST;
          rword_d    = WORD_LAST;
          addr_asm_d = addr_shifted;
          if (addr_cnt_q == '0) begin
            mem_address_d = addr_shifted;
            addr_cnt_d    = ADDR_LAST;
            pf_req        = 1'b1;
          end else begin
            addr_cnt_d = addr_cnt_q - 1'b1;
          end
        end
        {REGISTER_SELECT_DATA, BUS_WRITE}: begin
          for (int i = 0; i < TRANSACTIONS_PER_WORD; i++)
            if (wword_q == WCW'(i)) mem_write_data_d[i*WIDTH +: WIDTH] = s_bus;
          if (wword_q == '0) begin
            wr_strobe_d = 1'b1;
            step_d      = 1'b1;
            wword_d     = WORD_LAST;
          end else begin
            wword_d = wword_q - 1'b1;
          end
        end
        {REGISTER_SELECT_DATA, BUS_READ}: begin
          for (int i = 0; i < TRANSACTIONS_PER_WORD; i++)
            if (rword_q == WCW'(i)) bus_out_d = pf_buf_q[i*WIDTH +: WIDTH];
          if (rword_q == '0) begin
            step_d  = 1'b1;
            rword_d = WORD_LAST;
          end else begin
            rword_d = rword_q - 1'b1;
          end
        end
        default: err_ev = 1'b1;
      endcase
      if (err_ev) errors_d = sat_inc(errors_q);
    end

    case (pf_state_q)
      PF_IDLE: if (pf_req) pf_state_d = PF_REQ;
      PF_REQ:  pf_state_d = pf_req ? PF_REQ : PF_CAPTURE;
      PF_CAPTURE: begin
        pf_buf_d   = mem_read_data;
        pf_state_d = pf_req ? PF_REQ : PF_IDLE;
      end
      default: pf_state_d = PF_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_asm_q       <= '0;
      mem_address_q    <= '0;
      addr_cnt_q       <= ADDR_LAST;
      wword_q          <= WORD_LAST;
      rword_q          <= WORD_LAST;
      mem_write_data_q <= '0;
      pf_buf_q         <= '0;
      bus_out_q        <= '0;
      errors_q         <= '0;
      wr_strobe_q      <= 1'b0;
      step_q           <= 1'b0;
      ack_q            <= 1'b0;
      pf_state_q       <= PF_IDLE;
    end else begin
      addr_asm_q       <= addr_asm_d;
      mem_address_q    <= mem_address_d;
      addr_cnt_q       <= addr_cnt_d;
      wword_q          <= wword_d;
      rword_q          <= rword_d;
      mem_write_data_q <= mem_write_data_d;
      pf_buf_q         <= pf_buf_d;
      bus_out_q        <= bus_out_d;
      errors_q         <= errors_d;
      wr_strobe_q      <= wr_strobe_d;
      step_q           <= step_d;
      ack_q            <= ack_d;
      pf_state_q       <= pf_state_d;
    end
  end

  assign bus_out           = bus_out_q;
  assign bus_output_enable = s_read;
  assign ack_valid         = ack_q;
  assign mem_address       = mem_address_q;
  assign mem_write_data    = mem_write_data_q;
  assign mem_write_strobe  = wr_strobe_q;
  assign mem_read_strobe   = (pf_state_q == PF_REQ);
  assign errors            = errors_q;

endmodule
